// File: rtl/graphic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | graphic_pkg : shared types and widths for the ball/safe-zone path     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package graphic_pkg;

  localparam int XW      = $clog2(800);
  localparam int YW      = $clog2(600);
  localparam int SCORE_W = 16;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    CHECK      = 2'd1,
    MOVE       = 2'd2,
    DEAD       = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ball_motion_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ball_motion_ctrl_if : buttons, scan feed and ball/score outputs       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ball_motion_ctrl_if;
  import graphic_pkg::*;

  logic               i_frame_start;
  logic               i_btn_up;
  logic               i_btn_down;
  logic               i_btn_left;
  logic               i_btn_right;
  logic               i_btn_restart;
  logic               i_scan_valid;
  logic [XW-1:0]      i_scan_x;
  logic [YW-1:0]      i_scan_y;
  logic               i_is_safe;
  logic [XW-1:0]      o_ball_x;
  logic [YW-1:0]      o_ball_y;
  logic               o_game_over;
  logic [SCORE_W-1:0] o_score;

  modport slave (
    input  i_frame_start, i_btn_up, i_btn_down, i_btn_left, i_btn_right,
    input  i_btn_restart, i_scan_valid, i_scan_x, i_scan_y, i_is_safe,
    output o_ball_x, o_ball_y, o_game_over, o_score
  );

  modport master (
    output i_frame_start, i_btn_up, i_btn_down, i_btn_left, i_btn_right,
    output i_btn_restart, i_scan_valid, i_scan_x, i_scan_y, i_is_safe,
    input  o_ball_x, o_ball_y, o_game_over, o_score
  );

endinterface
`default_nettype wire

// File: rtl/ball_motion_ctrl_axis_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_step : one-axis step with clamp to [LO, HI], never wraps         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axis_step #(
  parameter int WIDTH = 10,
  parameter int LO    = 20,
  parameter int HI    = 779,
  parameter int STEP  = 4
) (
  input  wire logic [WIDTH-1:0] i_cur,
  input  wire logic             i_plus,
  input  wire logic             i_minus,
  output logic      [WIDTH-1:0] o_next
);

  // Two guard bits keep cur-STEP and cur+STEP representable before clamping.
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] c_lo   = SW'(LO);
  localparam logic signed [SW-1:0] c_hi   = SW'(HI);
  localparam logic signed [SW-1:0] c_step = SW'(STEP);

  logic signed [SW-1:0] w_cur;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_res;

  always_comb begin
    w_cur = $signed({2'b00, i_cur});
    w_sum = w_cur;
    if (i_plus && !i_minus) begin
      w_sum = w_cur + c_step;
    end else if (i_minus && !i_plus) begin
      w_sum = w_cur - c_step;
    end
    w_res = w_sum;
    if (w_sum < c_lo) begin
      w_res = c_lo;
    end else if (w_sum > c_hi) begin
      w_res = c_hi;
    end
    o_next = WIDTH'(w_res);
  end

endmodule
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ball_motion_ctrl : per-frame ball mover, centre-safety check, game FSM|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ball_motion_ctrl
  import graphic_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_RADIUS   = 20,
  parameter int STEP          = 4,
  parameter int START_X       = 400,
  parameter int START_Y       = 300
) (
  input wire logic           i_clk,
  input wire logic           i_rst,
  ball_motion_ctrl_if.slave  bus
);

  state_e             state_q, state_d;
  logic [XW-1:0]      ball_x_q, ball_x_d;
  logic [YW-1:0]      ball_y_q, ball_y_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_over_q, game_over_d;
  logic               centre_seen_q, centre_seen_d;
  logic               centre_safe_q, centre_safe_d;
  logic               restart_req_q, restart_req_d;

  logic [XW-1:0]      w_next_x;
  logic [YW-1:0]      w_next_y;
  logic               w_hit;
  logic               w_restart;

  axis_step #(
    .WIDTH (XW),
    .LO    (BALL_RADIUS),
    .HI    (SCREEN_WIDTH - 1 - BALL_RADIUS),
    .STEP  (STEP)
  ) u_step_x (
    .i_cur   (ball_x_q),
    .i_plus  (bus.i_btn_right),
    .i_minus (bus.i_btn_left),
    .o_next  (w_next_x)
  );

  // Y grows downward, so "down" is the plus direction.
  axis_step #(
    .WIDTH (YW),
    .LO    (BALL_RADIUS),
    .HI    (SCREEN_HEIGHT - 1 - BALL_RADIUS),
    .STEP  (STEP)
  ) u_step_y (
    .i_cur   (ball_y_q),
    .i_plus  (bus.i_btn_down),
    .i_minus (bus.i_btn_up),
    .o_next  (w_next_y)
  );

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    centre_seen_d = centre_seen_q;
    centre_safe_d = centre_safe_q;
    restart_req_d = restart_req_q;

    w_hit     = bus.i_scan_valid && (bus.i_scan_x == ball_x_q) && (bus.i_scan_y == ball_y_q);
    w_restart = restart_req_q || bus.i_btn_restart;

    if (state_q != DEAD && w_hit) begin
      centre_seen_d = 1'b1;
      centre_safe_d = bus.i_is_safe;
    end

    case (state_q)
      WAIT_FRAME: begin
        if (bus.i_frame_start) state_d = CHECK;
      end
      CHECK: begin
        if (centre_seen_q && !centre_safe_q) begin
          state_d       = DEAD;
          game_over_d   = 1'b1;
          restart_req_d = 1'b0;
        end else begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        ball_x_d      = w_next_x;
        ball_y_d      = w_next_y;
        score_d       = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
        centre_seen_d = 1'b0;
        state_d       = WAIT_FRAME;
      end
      DEAD: begin
        // A restart press in the same cycle as frame_start still counts.
        restart_req_d = w_restart;
        if (bus.i_frame_start && w_restart) begin
          ball_x_d      = XW'(START_X);
          ball_y_d      = YW'(START_Y);
          score_d       = '0;
          game_over_d   = 1'b0;
          centre_seen_d = 1'b0;
          restart_req_d = 1'b0;
          state_d       = WAIT_FRAME;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= WAIT_FRAME;
      ball_x_q      <= XW'(START_X);
      ball_y_q      <= YW'(START_Y);
      score_q       <= '0;
      game_over_q   <= 1'b0;
      centre_seen_q <= 1'b0;
      centre_safe_q <= 1'b1;
      restart_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      centre_seen_q <= centre_seen_d;
      centre_safe_q <= centre_safe_d;
      restart_req_q <= restart_req_d;
    end
  end

  assign bus.o_ball_x    = ball_x_q;
  assign bus.o_ball_y    = ball_y_q;
  assign bus.o_game_over = game_over_q;
  assign bus.o_score     = score_q;

endmodule
`default_nettype wire

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Per-frame controller for the ball/safe-zone display datapath. It owns the ball position and feeds the pixel renderer. It advances the ball once per frame, during vertical blanking, from button inputs, and clamps the ball to the screen. It watches the renderer's scan coordinates and safe flag to detect when the ball centre sits on unsafe background, and on that event freezes the game until a restart.

## Interface
Parameters:
- SCREEN_WIDTH, 800: horizontal resolution in pixels.
- SCREEN_HEIGHT, 600: vertical resolution in pixels.
- BALL_RADIUS, 20: clamp margin in pixels.
- STEP, 4: pixels moved per frame per axis.
- START_X, 400: start and restart X.
- START_Y, 300: start and restart Y.

Ports (XW = $clog2(SCREEN_WIDTH), YW = $clog2(SCREEN_HEIGHT)):
- i_clk  in  1: pixel clock. This is the only clock.
- i_rst  in  1: reset, asynchronous, active-high.
- i_frame_start  in  1: one-cycle pulse at the start of vertical blanking.
- i_btn_up, i_btn_down, i_btn_left, i_btn_right  in  1 each: levels, already synchronised.
- i_btn_restart  in  1: level, already synchronised.
- i_scan_valid  in  1: display enable for the current scan pixel.
- i_scan_x  in  XW: current scan X from the renderer.
- i_scan_y  in  YW: current scan Y from the renderer.
- i_is_safe  in  1: safe flag for the current scan pixel, same cycle as i_scan_x/y.
- o_ball_x  out  XW: registered ball centre X.
- o_ball_y  out  YW: registered ball centre Y.
- o_game_over  out  1: registered; high while in DEAD.
- o_score  out  16: frames survived, saturating.

## Operation
- **State machine.** States are WAIT_FRAME, CHECK, MOVE and DEAD. Reset state is WAIT_FRAME.
- **Centre sampling.** This runs in every state except DEAD. Sampling happens in any cycle with i_scan_valid=1, i_scan_x==o_ball_x and i_scan_y==o_ball_y. In that cycle: centre_safe <= i_is_safe and centre_seen <= 1.
- **WAIT_FRAME.** On i_frame_start, go to CHECK. Otherwise stay.
- **CHECK.**
  - If centre_seen=1 and centre_safe=0: go to DEAD, set o_game_over=1, clear restart_req.
  - Otherwise go to MOVE. An unseen centre (centre_seen=0) is treated as safe.
- **MOVE.**
  - Commit the next X and Y (see clamp rules below).
  - o_score <= o_score+1, saturating at 16'hFFFF.
  - Clear centre_seen and go to WAIT_FRAME.
- **Direction per axis.**
  - Right only gives +STEP. Left only gives −STEP.
  - Neither pressed, or both pressed, gives no change. Up/down on Y behave the same way.
  - Y increases downward.
- **Clamp arithmetic.**
  - Compute in signed arithmetic, 2 bits wider than the coordinate.
  - X result is clamped to [BALL_RADIUS, SCREEN_WIDTH−1−BALL_RADIUS]. Y is clamped the same way with SCREEN_HEIGHT.
  - The result never wraps.
- **DEAD.**
  - o_ball_x, o_ball_y and o_score are frozen. Sampling is disabled.
  - i_btn_restart=1 sets a sticky restart_req.
  - On i_frame_start with restart_req=1: ball returns to (START_X, START_Y), o_score=0, o_game_over=0, centre_seen=0, restart_req=0, and the state goes to WAIT_FRAME.
  - i_frame_start without restart_req is ignored.
- **Ignored pulses.** i_frame_start arriving while in CHECK or MOVE is ignored. Consecutive pulses are at least 3 cycles apart by system guarantee.
- **Simultaneous restart and frame_start.** The restart press is honoured on that same frame_start.

## Timing
- **Move latency.** i_frame_start at cycle t. CHECK at t+1. MOVE at t+2. New o_ball_x/y and o_score are visible from t+3.
- **Death latency.** o_game_over rises at t+2, in the cycle after CHECK. Position is unchanged.
- **Restart latency.** The restart commit is visible one cycle after the qualifying i_frame_start.
- **Registered outputs.** All outputs are registered. No combinational path runs from inputs to outputs.
- **Reset values.** o_ball_x=START_X, o_ball_y=START_Y, o_game_over=0, o_score=0, centre_seen=0, centre_safe=1, restart_req=0.
- **Reset mid-operation.** Reset asserted in any state, including mid-MOVE, returns everything to the reset values immediately. No partial commit survives.

## Structure
- **Shared package graphic_pkg.** It holds:
  - the state enum: WAIT_FRAME, CHECK, MOVE, DEAD;
  - the XW/YW width localparams;
  - the score width (16).
- **Sub-module axis_step.** Instantiated twice, once for X and once for Y. It is combinational.
  - Parameters: width, lo, hi, STEP.
  - Inputs: current coordinate, plus, minus.
  - Output: the clamped next coordinate.
- **Top level.** Holds the FSM, the sampler, restart_req and the score counter.

## Test plan
- **Reset.** Assert i_rst mid-run → ball (400,300), o_game_over=0, o_score=0 in the same cycle. Release, then 3 frames with no buttons → ball stays at (400,300) and o_score=3.
- **Move right.** Hold right, pulse i_frame_start at t → o_ball_x=404 at t+3. Holding right+up for one more frame → (408,296).
- **Clamp.** Hold right from x=776 → 779 after one frame, still 779 after the next. Hold up to y=20 → stays at 20 and never wraps.
- **Opposing buttons.** Hold left+right → X unchanged. Score still increments.
- **Death.** Drive scan (400,300) with i_scan_valid=1 and i_is_safe=0, then pulse frame_start at t → o_game_over=1 at t+2. Ball and score frozen across 5 more frames.
- **Restart.** In DEAD, pulse i_btn_restart 1 cycle, then frame_start → ball (400,300), o_score=0, o_game_over=0. Also apply restart and frame_start in the same cycle → same result.
